uart_tx_group_buffer: RTL
=========================

// Module: uart_tx_group_buffer
// PURPOSE
//  Transmit-side buffer between the cipher state machine and uart_tx.
//  - Captures output bytes into a FIFO and drives uart_tx one byte at a time.
//  - Formats the output stream into classic 5-letter groups:
//    - emits a space (0x20) after every GROUP_LEN data bytes;
//    - emits CR LF (0x0D 0x0A) in place of that space after every GROUPS_PER_LINE groups.
//  - Mirrors uart_rx on the return path of the host UART link.
// PARAMETERS
//  DEPTH            16  FIFO entries, power of two, >=2
//  GROUP_LEN        5   data bytes per group, 1..255
//  GROUPS_PER_LINE  6   groups per line before CR LF, 1..255
// PORTS
//  i_Clock      in   1  system clock (single clock domain)
//  i_Reset      in   1  synchronous, active-high reset
//  i_Byte_DV    in   1  one-cycle strobe: i_Byte is valid
//  i_Byte       in   8  data byte from the cipher state machine
//  i_Tx_Active  in   1  uart_tx o_Tx_Active
//  i_Tx_Done    in   1  uart_tx o_Tx_Done, one-cycle pulse at the end of the stop bit
//  o_Tx_DV      out  1  one-cycle start strobe to uart_tx i_Tx_DV
//  o_Tx_Byte    out  8  byte to uart_tx i_Tx_Byte; held from o_Tx_DV until i_Tx_Done
//  o_Full       out  1  FIFO count == DEPTH
//  o_Overflow   out  1  sticky: a write was dropped
// BEHAVIOUR
//  Reset
//  - Every output goes to 0: o_Tx_DV, o_Tx_Byte, o_Full, o_Overflow.
//  - FIFO is emptied; group and line counters are cleared; FSM enters IDLE.
//  - Reset mid-byte abandons the current byte. The block does not wait for i_Tx_Done.
//  FIFO
//  - Write: i_Byte_DV=1 and count<DEPTH. Written data is visible to the FSM next cycle.
//  - Fullness is judged on the count at the start of the cycle.
//    - i_Byte_DV while full drops the byte and sets o_Overflow, even if a pop happens that cycle.
//  - Pop and write in the same cycle are allowed when not full.
//  - Pointers are ADDR_W=$clog2(DEPTH) bits and wrap naturally.
//  - count is ADDR_W+1 bits.
//  FSM states
//  - IDLE
//    - If SEP_PEND: go to SEND with byte 0x20, 0x0D or 0x0A.
//    - Else if FIFO not empty and i_Tx_Active=0: pop the FIFO and go to SEND with that byte.
//  - SEND
//    - o_Tx_DV=1 for exactly one cycle, with o_Tx_Byte=byte.
//    - Then go to WAIT.
//  - WAIT
//    - Hold o_Tx_Byte. Stay until i_Tx_Done=1, then go to IDLE.
//    - i_Tx_Done seen in any state other than WAIT is ignored.
//  Separator logic (SEP_PEND is a 2-bit pending code)
//  - Data byte sent: grp_cnt increments.
//  - grp_cnt reaches GROUP_LEN: grp_cnt clears and line_cnt increments.
//    - If line_cnt reaches GROUPS_PER_LINE: line_cnt clears and CR then LF become pending.
//    - Otherwise a space becomes pending.
//  - Separators are emitted eagerly, before any further data and even if the FIFO is empty.
//  - Separators never consume FIFO entries.
//  Latency
//  - Byte into an empty, idle block at cycle 0 -> o_Tx_DV=1 at cycle 2.
//  - Back-to-back bytes are separated by exactly one IDLE cycle after i_Tx_Done.
//  Widths
//  - grp_cnt and line_cnt are 8 bits.
//  - The byte path is 8 bits and is passed through unmodified (no case or ASCII filtering).
// TESTING (bench uses the real uart_tx with CLKS_PER_BIT=4)
//  1. Reset, then 'A' strobed at cycle 0 -> o_Tx_DV at cycle 2 with byte 0x41.
//     Single UART frame on the line; no separator follows.
//  2. Burst of "ABCDE" on consecutive cycles -> line carries 41 42 43 44 45 20.
//     o_Full stays 0.
//  3. GROUPS_PER_LINE=2, 10 bytes "A".."J" -> 41..45 20 46..4A 0D 0A.
//     No space before CR.
//  4. DEPTH=16, 20 bytes on consecutive cycles while the UART is busy.
//     -> First 16 bytes are accepted, 4 are dropped.
//     -> o_Full=1 from cycle 16; o_Overflow=1 and stays 1.
//     -> Exactly the 16 accepted bytes are transmitted, with separators.
//  5. Assert i_Reset during WAIT of the third byte.
//     -> Next cycle all outputs are 0 and the FIFO is empty.
//     -> A new 'Z' produces 0x5A with grp_cnt restarted, so the space comes after 5 more bytes.
//  6. Stray i_Tx_Done pulse while IDLE with the FIFO empty -> no o_Tx_DV; counters unchanged.

Source files
------------

// File: rtl/uart_tx_group_buffer.sv
// Transmit buffer feeding uart_tx: byte FIFO plus 5-letter group formatting
// (space between groups, CR LF at the end of each line).
module uart_tx_group_buffer #(
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned GROUP_LEN       = 5,
    parameter int unsigned GROUPS_PER_LINE = 6
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Byte_DV,
    input  logic [7:0] i_Byte,
    input  logic       i_Tx_Active,
    input  logic       i_Tx_Done,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    output logic       o_Full,
    output logic       o_Overflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [7:0]       GRP_LEN_C = 8'(GROUP_LEN);
    localparam logic [7:0]       GPL_C     = 8'(GROUPS_PER_LINE);

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEP_NONE  = 2'd0,
        SEP_SPACE = 2'd1,
        SEP_CR    = 2'd2,
        SEP_LF    = 2'd3
    } sep_t;

    state_t            state, state_nxt;
    sep_t              sep_pend, sep_nxt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [7:0]        grp_cnt, grp_nxt;
    logic [7:0]        line_cnt, line_nxt;
    logic [7:0]        send_byte;
    logic [7:0]        grp_inc, line_inc;
    logic              wr_en, pop, load, is_full, is_empty;

    // Fullness is decided on the count at the start of the cycle, so a
    // simultaneous pop never rescues a write to a full FIFO.
    assign is_full  = (count == DEPTH_C);
    assign is_empty = (count == CNT_W'(0));
    assign wr_en    = i_Byte_DV && !is_full;
    assign grp_inc  = grp_cnt + 8'd1;
    assign line_inc = line_cnt + 8'd1;

    always_comb begin
        case ({wr_en, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Next-state, pop decision and separator bookkeeping.
    always_comb begin
        state_nxt = state;
        sep_nxt   = sep_pend;
        grp_nxt   = grp_cnt;
        line_nxt  = line_cnt;
        pop       = 1'b0;
        load      = 1'b0;
        send_byte = 8'h00;
        case (state)
            IDLE: begin
                if (sep_pend != SEP_NONE) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                    case (sep_pend)
                        SEP_SPACE: begin send_byte = CH_SPACE; sep_nxt = SEP_NONE; end
                        SEP_CR:    begin send_byte = CH_CR;    sep_nxt = SEP_LF;   end
                        default:   begin send_byte = CH_LF;    sep_nxt = SEP_NONE; end
                    endcase
                end else if (!is_empty && !i_Tx_Active) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    send_byte = mem[rd_ptr];
                    state_nxt = SEND;
                    if (grp_inc == GRP_LEN_C) begin
                        grp_nxt = 8'd0;
                        if (line_inc == GPL_C) begin
                            line_nxt = 8'd0;
                            sep_nxt  = SEP_CR;
                        end else begin
                            line_nxt = line_inc;
                            sep_nxt  = SEP_SPACE;
                        end
                    end else begin
                        grp_nxt = grp_inc;
                    end
                end
            end
            SEND:    state_nxt = WAIT;
            WAIT:    if (i_Tx_Done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage carries no reset; validity is tracked by count.
    always_ff @(posedge i_Clock) begin
        if (wr_en) mem[wr_ptr] <= i_Byte;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state      <= IDLE;
            sep_pend   <= SEP_NONE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            grp_cnt    <= 8'd0;
            line_cnt   <= 8'd0;
            o_Tx_DV    <= 1'b0;
            o_Tx_Byte  <= 8'h00;
            o_Full     <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            state      <= state_nxt;
            sep_pend   <= sep_nxt;
            grp_cnt    <= grp_nxt;
            line_cnt   <= line_nxt;
            count      <= count_nxt;
            o_Full     <= (count_nxt == DEPTH_C);
            o_Overflow <= o_Overflow | (i_Byte_DV && is_full);
            o_Tx_DV    <= load;
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
            if (load)  o_Tx_Byte <= send_byte;
        end
    end

endmodule
